// File: rtl/sw_debounce.sv
// Switch/button debouncer: a two-flop synchroniser followed by a stability counter.
// Define SW_DEBOUNCE_EDGE_EN to build the registered RISE/FALL pulse outputs.
module sw_debounce #(
    parameter int   STABLE_CNT = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic CK,
    input  logic RST_n,
    input  logic D_RAW,
    output logic Q,
    output logic RISE,
    output logic FALL
);

    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

    typedef enum logic {MATCH, COUNT} state_e;

    logic          s1_q, s2_q;
    logic          q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;
    state_e        state;

    always_ff @(posedge CK or negedge RST_n) begin
        if (!RST_n) begin
            s1_q  <= INIT_LEVEL;
            s2_q  <= INIT_LEVEL;
            q_q   <= INIT_LEVEL;
            cnt_q <= '0;
        end else begin
            s1_q  <= D_RAW;
            s2_q  <= s1_q;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    // Any cycle in which s2 agrees with Q discards the partial count.
    always_comb begin
        state = (s2_q == q_q) ? MATCH : COUNT;
        cnt_d = '0;
        q_d   = q_q;
        flip  = 1'b0;
        case (state)
            MATCH: cnt_d = '0;
            COUNT: begin
                if (cnt_q == CNT_MAX) begin
                    flip = 1'b1;
                    q_d  = s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign Q = q_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge CK or negedge RST_n) begin
        if (!RST_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= flip &  s2_q;
            fall_q <= flip & ~s2_q;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (STABLE_CNT=4, INIT_LEVEL=0, 20 ns clock).
module tb_sw_debounce;

    logic CK, RST_n, D_RAW;
    logic Q, RISE, FALL;

    int checks   = 0;
    int failures = 0;

    sw_debounce #(.STABLE_CNT(4), .INIT_LEVEL(1'b0)) dut (
        .CK   (CK),
        .RST_n(RST_n),
        .D_RAW(D_RAW),
        .Q    (Q),
        .RISE (RISE),
        .FALL (FALL)
    );

    initial CK = 1'b0;
    always #10 CK = ~CK;

    typedef struct {
        logic d;
        logic q;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs[$];

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    function automatic void v(input logic d, input logic q, input logic r, input logic f);
        vec_t t;
        t.d = d; t.q = q; t.rise = r & EDGE_EN; t.fall = f & EDGE_EN;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int idx, input logic q, input logic r, input logic f);
        chk({name, ".Q"},    idx, {3'b0, Q},    {3'b0, q});
        chk({name, ".RISE"}, idx, {3'b0, RISE}, {3'b0, r & EDGE_EN});
        chk({name, ".FALL"}, idx, {3'b0, FALL}, {3'b0, f & EDGE_EN});
    endtask

    initial begin
        // Clean rise: Q follows at the 6th edge
        for (int i = 1; i <= 8; i++) v(1'b1, i >= 6, i == 6, 1'b0);
        // Clean fall
        for (int i = 1; i <= 8; i++) v(1'b0, i < 6, 1'b0, i == 6);
        // Glitch of 3 cycles: rejected
        for (int i = 1; i <= 3; i++) v(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) v(1'b0, 1'b0, 1'b0, 1'b0);
        // Pulse of exactly 4 cycles: accepted, then falls back 4 edges later
        for (int i = 1; i <= 4; i++) v(1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b1, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b1, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 1'b0, 1'b0);
        // Chatter 2-high/2-low, then settle high: Q rises at edge 14
        for (int i = 1; i <= 16; i++) begin
            logic d;
            d = (i >= 9) ? 1'b1 : (((i - 1) % 4) < 2);
            v(d, i >= 14, i == 14, 1'b0);
        end
        // Return to Q=0
        for (int i = 1; i <= 8; i++) v(1'b0, i < 6, 1'b0, i == 6);

        // Reset hold with D_RAW toggling every 10 ns
        RST_n = 1'b0;
        D_RAW = 1'b0;
        #1;
        chk_out("reset_t0", 0, 1'b0, 1'b0, 1'b0);
        #3;
        for (int i = 0; i < 10; i++) begin
            D_RAW = ~D_RAW;
            #5;
            chk_out("reset_hold", i, 1'b0, 1'b0, 1'b0);
            #5;
        end
        @(negedge CK);
        RST_n = 1'b1;
        D_RAW = 1'b0;

        foreach (vecs[i]) begin
            @(negedge CK);
            D_RAW = vecs[i].d;
            @(posedge CK);
            #1;
            chk_out("vec", i, vecs[i].q, vecs[i].rise, vecs[i].fall);
        end

        // Reset in the middle of a count (cnt=2)
        @(negedge CK);
        D_RAW = 1'b1;
        repeat (4) @(posedge CK);
        #1;
        chk("midrst_cnt_before", 0, 4'(dut.cnt_q), 4'd2);
        @(negedge CK);
        RST_n = 1'b0;
        #1;
        chk_out("midrst_async", 0, 1'b0, 1'b0, 1'b0);
        chk("midrst_cnt", 0, 4'(dut.cnt_q), 4'd0);
        chk("midrst_sync", 0, {2'b0, dut.s1_q, dut.s2_q}, 4'd0);
        @(negedge CK);
        RST_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CK);
            #1;
            chk_out("midrst_release", i, i >= 6, i == 6, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion before 100000 ns");
        $fatal(1);
    end

endmodule
